// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_mux
// Purpose  : Time-multiplexed scanner for a multi-digit 7-segment display.
//            It holds a BCD value and steps through the digits at a
//            programmable slot rate. A value written mid-frame is held in a
//            pending buffer and only becomes visible at the next frame
//            boundary, so a frame never shows a mix of old and new digits.
// Ports    :
//    clk          system clock
//    rst_n        asynchronous active-low reset
//    value_in     BCD nibbles, nibble 0 (bits 3:0) = least significant digit
//    load         capture value_in this cycle
//    blank_lz     1 = suppress leading zeros
//    digit_out    code to the 7-segment decoder (4'hF = blank)
//    digit_an     one-hot digit select, polarity set by AN_ACTIVE_LOW
//    digit_idx    index of the digit currently driven
//    frame_start  one-cycle pulse with the first output cycle of digit 0
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_mux #(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_DIV   = 50000,
   parameter int GUARD         = 16,
   parameter int AN_ACTIVE_LOW = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [4*NUM_DIGITS-1:0]         value_in,
   input  logic                            load,
   input  logic                            blank_lz,
   output logic [3:0]                      digit_out,
   output logic [NUM_DIGITS-1:0]           digit_an,
   output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
   output logic                            frame_start
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [CNT_W-1:0]      LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0]      GUARD_CNT = CNT_W'(GUARD);
   localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
   // XOR mask that turns an active-high select into the configured polarity;
   // it is also the "all selects off" pattern.
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = (AN_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} :
                                                 {NUM_DIGITS{1'b0}};

   logic [CNT_W-1:0]        pre_cnt;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] pending;
   logic                    pending_valid;
   logic [4*NUM_DIGITS-1:0] active;
   // Set during the first state cycle of a new frame; frame_start is this
   // delayed by the output register so it lines up with digit 0 on the pins.
   logic                    wrapped;

   logic                    terminal;
   logic                    wrap;
   logic [3:0]              nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zero_above;
   logic                    all_zero;
   logic                    blanked;
   logic [3:0]              digit_next;
   logic [NUM_DIGITS-1:0]   sel;
   logic [NUM_DIGITS-1:0]   an_next;

   assign terminal = (pre_cnt == LAST_CNT);
   assign wrap     = terminal && (idx == LAST_IDX);

   // ------------------------------------------------------------------------
   // Slot prescaler and digit index
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         idx     <= '0;
         wrapped <= 1'b0;
      end else begin
         wrapped <= wrap;
         if (terminal) begin
            pre_cnt <= '0;
            idx     <= wrap ? '0 : idx + 1'b1;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Double buffer: loads land in pending and are committed at the wrap.
   // A load on the wrap cycle itself goes straight to active, superseding
   // anything still pending.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending       <= '0;
         pending_valid <= 1'b0;
         active        <= '0;
      end else if (wrap) begin
         pending_valid <= 1'b0;
         if (load) begin
            active <= value_in;
         end else if (pending_valid) begin
            active <= pending;
         end
      end else if (load) begin
         pending       <= value_in;
         pending_valid <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Digit selection and leading-zero blanking
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign nib[gi] = active[4*gi +: 4];
   end

   // zero_above[i] = nibble i and every more significant nibble are zero.
   always_comb begin
      all_zero   = 1'b1;
      zero_above = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero      = all_zero & (nib[i] == 4'd0);
         zero_above[i] = all_zero;
      end
   end

   // Digit 0 is never blanked so a zero value still shows a single "0".
   assign blanked    = blank_lz && (idx != '0) && zero_above[idx];
   assign digit_next = blanked ? 4'hF : nib[idx];

   always_comb begin
      sel      = '0;
      sel[idx] = 1'b1;
   end

   // Selects stay off for the first GUARD cycles of each slot so the
   // previous digit's segments never ghost onto the new digit.
   assign an_next = (pre_cnt >= GUARD_CNT) ? sel : '0;

   // ------------------------------------------------------------------------
   // Registered outputs (one cycle behind the scan state)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_out   <= 4'hF;
         digit_an    <= AN_OFF;
         digit_idx   <= '0;
         frame_start <= 1'b0;
      end else begin
         digit_out   <= digit_next;
         digit_an    <= an_next ^ AN_OFF;
         digit_idx   <= idx;
         frame_start <= wrapped;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_scan_mux
// Purpose  : Self-checking bench for display_scan_mux (4 digits, 4-cycle
//            slots, 1-cycle guard, active-low selects). Expected outputs
//            come from a time-based model: slot and position follow from the
//            cycle count since reset, and the value shown in frame F is the
//            most recent load made before frame F began.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_scan_mux;

   localparam int ND = 4;
   localparam int RD = 4;
   localparam int GD = 1;
   localparam int FR = ND * RD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value_in;
   logic        load;
   logic        blank_lz;
   logic [3:0]  digit_out;
   logic [3:0]  digit_an;
   logic [1:0]  digit_idx;
   logic        frame_start;

   logic [10:0] obs;
   logic [10:0] exp_v;

   typedef struct {
      int          t;
      logic [15:0] v;
   } load_t;

   load_t loads[$];
   int    n;
   int    checks;
   int    errors;

   display_scan_mux #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .GUARD        (GD),
      .AN_ACTIVE_LOW(1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .value_in   (value_in),
      .load       (load),
      .blank_lz   (blank_lz),
      .digit_out  (digit_out),
      .digit_an   (digit_an),
      .digit_idx  (digit_idx),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   assign obs = {digit_out, digit_an, digit_idx, frame_start};

   // ---------------- reference model ----------------
   function automatic logic [15:0] model_active(input int f);
      logic [15:0] r;
      r = 16'h0000;
      foreach (loads[i]) begin
         if (loads[i].t < f * FR) r = loads[i].v;
      end
      return r;
   endfunction

   function automatic logic [3:0] exp_digit(input logic [15:0] a, input int s,
                                            input logic blz);
      if (blz && s != 0 && (a >> (4 * s)) == 16'h0000) return 4'hF;
      return a[4*s +: 4];
   endfunction

   function automatic logic [3:0] exp_an(input int s, input int p);
      logic [3:0] m;
      m = 4'b0001 << s;
      return (p >= GD) ? ~m : 4'hF;
   endfunction

   // One clock of stimulus; exp_v then holds what the outputs must show.
   task automatic step(input logic ld, input logic [15:0] v, input logic blz);
      int          s;
      int          p;
      logic [15:0] a;
      @(negedge clk);
      load     = ld;
      value_in = v;
      blank_lz = blz;
      @(posedge clk);
      s     = (n / RD) % ND;
      p     = n % RD;
      a     = model_active(n / FR);
      exp_v = {exp_digit(a, s, blz), exp_an(s, p), s[1:0], (n > 0 && n % FR == 0)};
      if (ld) loads.push_back('{n, v});
      n++;
      #1;
   endtask

   task automatic model_restart();
      n = 0;
      loads.delete();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n    = 1'b0;
      load     = 1'b0;
      value_in = 16'h0000;
      blank_lz = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (obs !== {4'hF, 4'hF, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state k=%0d got %h expected %h", k, obs, {4'hF, 4'hF, 2'd0, 1'b0});
         end
      end
      #1 rst_n = 1'b1;
      model_restart();
   endtask

   task automatic test_idle_scan();
      for (int k = 0; k < 40; k++) begin
         step(1'b0, 16'($urandom), 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL idle_scan t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
   endtask

   task automatic test_load_midframe();
      while (n % FR != 6) begin
         step(1'b0, 16'h0000, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL midframe_pre t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
      step(1'b1, 16'h1234, 1'b0);
      for (int k = 0; k < 30; k++) begin
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL midframe_load t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
         step(1'b0, 16'($urandom), 1'b0);
      end
   endtask

   task automatic test_blanking();
      logic [15:0] vals [3];
      logic        blz  [3];
      vals[0] = 16'h0050; blz[0] = 1'b1;
      vals[1] = 16'h0000; blz[1] = 1'b1;
      vals[2] = 16'h0000; blz[2] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         while (n % FR != 10) begin
            step(1'b0, 16'h0000, blz[c]);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL blank_pre c=%0d t=%0d got %h expected %h", c, n - 1, obs, exp_v);
            end
         end
         step(1'b1, vals[c], blz[c]);
         for (int k = 0; k < FR + 8; k++) begin
            step(1'b0, 16'h0000, blz[c]);
            checks++;
            if (obs !== exp_v) begin
               errors++;
               $display("FAIL blank_show c=%0d t=%0d got %h expected %h", c, n - 1, obs, exp_v);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      while (n % FR != 2) begin
         step(1'b0, 16'h0000, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b_pre t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
      step(1'b1, 16'h1111, 1'b0);
      while (n % FR != 9) step(1'b0, 16'h0000, 1'b0);
      step(1'b1, 16'h2222, 1'b0);
      for (int k = 0; k < FR + 10; k++) begin
         step(1'b0, 16'h0000, 1'b0);
         checks++;
         if (obs !== exp_v || digit_out === 4'h1) begin
            errors++;
            $display("FAIL back_to_back t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
   endtask

   task automatic test_wrap_bypass();
      while (n % FR != 3) step(1'b0, 16'h0000, 1'b0);
      // Leaves a stale pending value that the wrap-cycle load must discard.
      step(1'b1, 16'h5555, 1'b0);
      while (n % FR != FR - 1) step(1'b0, 16'h0000, 1'b0);
      step(1'b1, 16'h9999, 1'b0);
      for (int k = 0; k < 2 * FR + 2; k++) begin
         step(1'b0, 16'h0000, 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL wrap_bypass t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      while (n % FR != 5) step(1'b0, 16'h0000, 1'b0);
      step(1'b1, 16'h7777, 1'b0);
      while (n % FR != 9) step(1'b0, 16'h0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== {4'hF, 4'hF, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_now got %h expected %h", obs, {4'hF, 4'hF, 2'd0, 1'b0});
      end
      @(posedge clk);
      #1;
      checks++;
      if (obs !== {4'hF, 4'hF, 2'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset_hold got %h expected %h", obs, {4'hF, 4'hF, 2'd0, 1'b0});
      end
      #1 rst_n = 1'b1;
      model_restart();
      for (int k = 0; k < 2 * FR + 4; k++) begin
         step(1'b0, 16'($urandom), 1'b0);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL after_reset t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
   endtask

   task automatic test_random();
      logic blz;
      blz = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 15) == 0) blz = ~blz;
         step($urandom_range(0, 7) == 0, 16'($urandom), blz);
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL random t=%0d got %h expected %h", n - 1, obs, exp_v);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      n      = 0;
      test_reset();
      test_idle_scan();
      test_load_midframe();
      test_blanking();
      test_back_to_back();
      test_wrap_bypass();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
Time-multiplexed scanner for a common-anode/cathode multi-digit 7-segment display. It holds a BCD value and steps through the digits at a programmable refresh rate. Each slot drives one 4-bit digit code to the downstream 7-segment decoder and asserts the matching digit-select line. Value updates are double-buffered at frame boundaries, so the display never tears mid-scan.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
REFRESH_DIV, 50000, clk cycles per digit slot (must be > GUARD)
GUARD, 16, cycles at the start of each slot with all selects inactive (anti-ghosting)
AN_ACTIVE_LOW, 1, 1 = digit selects active-low, 0 = active-high

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
value_in  in  4*NUM_DIGITS  BCD nibbles; nibble 0 (bits 3:0) = least significant digit
load  in  1  capture value_in into pending buffer this cycle
blank_lz  in  1  1 = suppress leading zeros
digit_out  out  4  code to the 7-segment decoder; 4'hF = blank (decoder shows all segments off for codes above 9)
digit_an  out  NUM_DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW
digit_idx  out  clog2(NUM_DIGITS)  index of the digit currently driven
frame_start  out  1  one-cycle pulse when the scan wraps to digit 0

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset state:
  - pre_cnt=0, idx=0, pending=0, pending_valid=0, active=0.
  - digit_out=4'hF, digit_an all inactive, digit_idx=0, frame_start=0.
  - Reset mid-slot or mid-frame aborts the scan immediately. The previously loaded value is lost.
- Prescaler: pre_cnt counts 0..REFRESH_DIV-1 every cycle. At terminal count it returns to 0 and idx advances: idx+1, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary (wrap cycle) = terminal count with idx==NUM_DIGITS-1. On that edge:
  - frame_start=1 for exactly one cycle, aligned with the first output cycle of digit 0.
  - If pending_valid, active<=pending and pending_valid<=0.
- Load:
  - load=1 outside the wrap cycle: pending<=value_in, pending_valid<=1. The last load before a wrap wins.
  - load=1 on the wrap cycle: active<=value_in directly (bypass), pending_valid<=0.
- Leading-zero blanking, when blank_lz=1: digit i is blanked if active nibble i and every higher nibble are 0. Digit 0 is never blanked, so a value of 0 shows a single "0". blank_lz is sampled every cycle and takes effect immediately.
- Nibbles 10..15 in active are passed through unchanged; the decoder blanks them. Only zero nibbles count for blanking.
- Outputs are registered with 1-cycle latency: outputs at cycle t+1 reflect pre_cnt/idx/active at cycle t.
  - digit_out = blanked ? 4'hF : active nibble idx.
  - digit_idx = idx.
  - digit_an = one-hot(idx) when pre_cnt >= GUARD, all-zero otherwise. The result is inverted if AN_ACTIVE_LOW=1.
- Exactly one select is active at any time outside guard windows. No select is ever active during the first GUARD cycles of a slot.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles. It is independent of load and blank_lz activity.

Test Plan:
(Bench uses NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, AN_ACTIVE_LOW=1.)
1. Reset then idle:
   - During rst_n=0: digit_out=F, digit_an=4'b1111.
   - After release: digit_idx sequence 0,0,0,0,1,1,1,1,2.. with frame_start every 16 cycles.
   - digit_an=4'b1110 only on cycles 2-4 of slot 0.
2. load value_in=16'h1234 mid-frame:
   - The display keeps showing 0000 until the next frame_start.
   - From then on, digit_out per slot = 4,3,2,1.
3. blank_lz=1, active=16'h0050:
   - Slots 0..3 show 0, 5, F, F.
   - active=16'h0000 shows 0, F, F, F.
   - blank_lz=0 shows 0, 0, 0, 0.
4. Two loads (16'h1111, then 16'h2222) in the same frame: 2222 is displayed after the wrap; 1111 never appears.
5. load 16'h9999 exactly on the wrap cycle: digit 0 of the new frame shows 9 (bypass), and pending_valid=0 afterwards.
6. Assert rst_n low in slot 2 for 1 cycle:
   - Outputs go to reset values immediately, asynchronously.
   - After release the scan restarts at idx=0 with active=0.
